button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Collects single-cycle edge pulses from up to WIDTH edge-detected input channels (buttons and switches) and turns them into an ordered stream of event IDs for the CPU's memory-mapped I/O. It holds one pending flag per channel and grants pending channels round-robin into a small FIFO. The FIFO head is exposed through a valid/ready handshake, and lost events are counted. It sits between the edge-detector bank in the I/O circuits and the MMIO read path.

## Interface
- WIDTH, 4: number of pulse channels, 2..16.
- DEPTH, 8: event FIFO entries, power of two, 2..32.
- ID_W, $clog2(WIDTH): event ID width, derived, not overridden.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- pulse_in  input  WIDTH  one-cycle edge pulses; bit i is channel i.
- event_ready  input  1  consumer accepts the head event this cycle.
- event_valid  output  1  FIFO non-empty; event_id is meaningful.
- event_id  output  ID_W  channel number of the oldest queued event.
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- drop_clear  input  1  clears drop_count.
- drop_count  output  8  saturating count of lost pulses.

## Operation
- Pending flags pend[WIDTH-1:0]:
  - pulse_in[i]=1 sets pend[i] at the clock edge.
  - A grant of channel i clears pend[i] at the same edge.
  - If pulse_in[i] and a grant of i coincide, pend[i] ends at 1. This is a new event, not a drop.
- Grant enable: grant_en = (fifo_count < DEPTH) || (event_valid && event_ready). A pop frees space for a push in the same cycle.
- Round-robin:
  - ptr holds the last granted channel.
  - The search starts at ptr+1, wraps modulo WIDTH, and picks the first set pend bit.
  - At most one grant per cycle.
  - On a grant, ptr takes the granted index and the index is pushed into the FIFO.
  - With no grant, ptr holds.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap naturally.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop happens when event_valid && event_ready. event_ready while empty is ignored.
- Drop accounting: a drop occurs on channel i when pulse_in[i]=1, pend[i]=1 and i is not granted this cycle.
  - drop_count adds the number of drops in the cycle, which can be several.
  - It saturates at 255.
  - drop_clear=1 forces drop_count to 0 and discards that cycle's drops.
- When the FIFO is full and no pop occurs, there is no grant. Pending flags hold and later pulses on pending channels count as drops.

## Timing
- Reset values:
  - pend=0
  - ptr=WIDTH-1, so the first search starts at channel 0
  - FIFO empty: event_valid=0, fifo_count=0
  - event_id=0
  - drop_count=0
- Reset wins over every other input in the same cycle. Reset mid-operation discards all pending and queued events.
- Latency on an empty, idle FIFO:
  - Cycle N: pulse on channel i.
  - Cycle N+1: pend[i]=1, grant is combinational, push at the end of N+1.
  - Cycle N+2: event_valid=1 and event_id=i.
- event_valid, event_id and fifo_count come directly from registers and the FIFO read pointer. There is no combinational path from pulse_in.
- event_id is stable while event_valid=1 and event_ready=0.
- Sustained throughput is one event per cycle with event_ready held high.
- drop_count updates at the edge following the dropping pulse.

## Test plan
- Reset with pulse_in=4'b1111 and rst=1 for 2 cycles, then release: event_valid=0, fifo_count=0, drop_count=0. Pulses during reset are not captured.
- Single pulse on channel 2 at cycle 10, event_ready=1: event_valid=1 and event_id=2 in cycle 12 only, then fifo_count returns to 0.
- Simultaneous pulses 4'b1011 after reset, event_ready=1: events appear in order 0, 1, 3 in cycles N+2..N+4. A following pulse 4'b0011 yields 0, 1, confirming the pointer wrap.
- DEPTH=8, event_ready=0, ten pulses on channels in turn 0..3 spaced 2 cycles apart: FIFO fills to 8 and event_valid stays high. The extra pulses stay pending or count as drops. fifo_count never exceeds 8, and drop_count equals the lost pulses. Raising event_ready drains 8 events in order, then the remaining pending events.
- Full FIFO with event_ready=1 and channel 1 pending: a pop and a push occur in the same cycle, fifo_count stays at 8, and ID 1 lands at the tail.
- Channel 0 held pending (FIFO full) while 300 pulses arrive: drop_count saturates at 255. drop_clear=1 for one cycle gives drop_count=0.

Source files
------------

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : button_event_arbiter
// Purpose  : Round-robin arbiter turning per-channel edge pulses into a FIFO
//            of event IDs with a valid/ready head and a saturating drop count.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int ID_W  = $clog2(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           pulse_in,
    input  logic                       event_ready,
    output logic                       event_valid,
    output logic [ID_W-1:0]            event_id,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic                       drop_clear,
    output logic [7:0]                 drop_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_pend;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [7:0]         r_drop;

    logic               w_hi_found;
    logic [ID_W-1:0]    w_hi_idx;
    logic               w_lo_found;
    logic [ID_W-1:0]    w_lo_idx;
    logic               w_gnt_vld;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_pop;
    logic               w_grant_en;
    logic               w_push;
    logic [WIDTH-1:0]   w_gnt_vec;
    logic [WIDTH-1:0]   w_drops;
    logic [4:0]         w_drop_n;
    logic [8:0]         w_drop_sum;
    logic [7:0]         w_drop_next;

    // Lowest pending index above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = ID_W'(i);
                if (i > int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(i);
                end
            end
        end
    end

    assign w_gnt_vld  = w_hi_found | w_lo_found;
    assign w_gnt_idx  = w_hi_found ? w_hi_idx : w_lo_idx;

    assign event_valid = (r_count != '0);
    assign w_pop       = event_valid & event_ready;
    assign w_grant_en  = (r_count < c_CNT_W'(DEPTH)) | w_pop;
    assign w_push      = w_gnt_vld & w_grant_en;
    assign w_gnt_vec   = w_push ? (WIDTH'(1) << w_gnt_idx) : '0;

    // A pulse landing on the channel being granted re-arms it rather than dropping.
    assign w_drops = pulse_in & r_pend & ~w_gnt_vec;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_drop_n = w_drop_n + 5'(w_drops[i]);
        end
    end

    assign w_drop_sum  = 9'(r_drop) + 9'(w_drop_n);
    assign w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_ptr   <= ID_W'(WIDTH - 1);
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_pend <= (r_pend & ~w_gnt_vec) | pulse_in;
            if (w_push) begin
                r_ptr         <= w_gnt_idx;
                r_mem[r_wptr] <= w_gnt_idx;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_drop <= drop_clear ? 8'h00 : w_drop_next;
        end
    end

    assign event_id   = r_mem[r_rptr];
    assign fifo_count = r_count;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_arbiter
// Purpose  : Directed vector table plus multi-cycle sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pulse_in;
    logic       event_ready;
    logic       event_valid;
    logic [1:0] event_id;
    logic [3:0] fifo_count;
    logic       drop_clear;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .WIDTH (4),
        .DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .event_ready (event_ready),
        .event_valid (event_valid),
        .event_id    (event_id),
        .fifo_count  (fifo_count),
        .drop_clear  (drop_clear),
        .drop_count  (drop_count)
    );

    typedef struct {
        logic       r;
        logic [3:0] p;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] id;
        logic [3:0] cnt;
        logic [7:0] drp;
    } vec_t;

    vec_t tbl[$];
    int   exp_q[8];

    task automatic add(input logic r, input logic [3:0] p, input logic rdy, input logic clr,
                       input logic ev, input logic [1:0] id, input logic [3:0] cnt,
                       input logic [7:0] drp);
        vec_t v;
        v.r = r; v.p = p; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.id = id; v.cnt = cnt; v.drp = drp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pulse_in = '0; event_ready = 1'b0; drop_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_ch(input int ch);
        pulse_in = 4'(1 << ch);
        tick();
        chk("count_bound", 32'(fifo_count <= 4'd8), 1);
        pulse_in = '0;
        tick();
        chk("count_bound", 32'(fifo_count <= 4'd8), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset with all pulses asserted; none may be captured.
        rst = 1'b1; pulse_in = 4'b1111; event_ready = 1'b1; drop_clear = 1'b0;
        tick();
        tick();

        //   rst  pulse    rdy  clr   valid id     cnt   drop
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);   // 0 reset state
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b1011, 1, 0,  0, 2'd0, 4'd0, 8'd0);   // 2 simultaneous pulses
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd0, 4'd1, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd1, 4'd1, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd3, 4'd1, 8'd0);
        add(0, 4'b0011, 1, 0,  0, 2'd0, 4'd0, 8'd0);   // 7 pointer wrap
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd0, 4'd1, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd1, 4'd1, 8'd0);
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0100, 1, 0,  0, 2'd0, 4'd0, 8'd0);   // 12 single pulse ch2
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd2, 4'd1, 8'd0);
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0001, 1, 0,  0, 2'd0, 4'd0, 8'd0);   // 16 pulse coincides with grant
        add(0, 4'b0001, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd0, 4'd1, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd0, 4'd1, 8'd0);
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0011, 1, 0,  0, 2'd0, 4'd0, 8'd0);   // 21 single drop on ch0
        add(0, 4'b0001, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd1, 4'd1, 8'd1);
        add(0, 4'b0000, 1, 0,  1, 2'd0, 4'd1, 8'd1);
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd1);
        add(0, 4'b0000, 1, 1,  0, 2'd0, 4'd0, 8'd1);   // 26 clear
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b1111, 1, 0,  0, 2'd0, 4'd0, 8'd0);   // 28 three drops in one cycle
        add(0, 4'b1111, 1, 0,  0, 2'd0, 4'd0, 8'd0);
        add(0, 4'b0000, 1, 0,  1, 2'd1, 4'd1, 8'd3);
        add(0, 4'b0000, 1, 0,  1, 2'd2, 4'd1, 8'd3);
        add(0, 4'b0000, 1, 0,  1, 2'd3, 4'd1, 8'd3);
        add(0, 4'b0000, 1, 0,  1, 2'd0, 4'd1, 8'd3);
        add(0, 4'b0000, 1, 0,  1, 2'd1, 4'd1, 8'd3);
        add(0, 4'b0000, 1, 1,  0, 2'd0, 4'd0, 8'd3);
        add(0, 4'b0000, 1, 0,  0, 2'd0, 4'd0, 8'd0);

        foreach (tbl[i]) begin
            rst         = tbl[i].r;
            pulse_in    = tbl[i].p;
            event_ready = tbl[i].rdy;
            drop_clear  = tbl[i].clr;
            chk($sformatf("vec%0d_valid", i), 32'(event_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count),  32'(tbl[i].cnt));
            chk($sformatf("vec%0d_drop", i),  32'(drop_count),  32'(tbl[i].drp));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_id", i), 32'(event_id), 32'(tbl[i].id));
            end
            tick();
        end

        // Fill to DEPTH with the consumer stalled, then overflow into pending/drops.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            pulse_ch(k % 4);
        end
        pulse_ch(0);
        chk("full_count", 32'(fifo_count), 8);
        chk("full_valid", 32'(event_valid), 1);
        chk("full_id",    32'(event_id), 0);
        chk("full_drop",  32'(drop_count), 1);

        // Pop and push in the same cycle keep the FIFO at 8.
        event_ready = 1'b1;
        tick();
        chk("poppush0_count", 32'(fifo_count), 8);
        chk("poppush0_id",    32'(event_id), 1);
        tick();
        chk("poppush1_count", 32'(fifo_count), 8);
        chk("poppush1_id",    32'(event_id), 2);

        exp_q = '{2, 3, 0, 1, 2, 3, 0, 1};
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d_valid", j), 32'(event_valid), 1);
            chk($sformatf("drain%0d_id", j),    32'(event_id), 32'(exp_q[j]));
            tick();
        end
        chk("drained_valid", 32'(event_valid), 0);
        chk("drained_count", 32'(fifo_count), 0);
        chk("drained_drop",  32'(drop_count), 1);

        // Saturation: ch0 stays pending behind a full FIFO.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            pulse_ch(k % 4);
        end
        chk("sat_full_count", 32'(fifo_count), 8);
        pulse_in = 4'b0001;
        tick();
        repeat (200) tick();
        chk("sat_drop200", 32'(drop_count), 200);
        repeat (100) tick();
        chk("sat_drop255", 32'(drop_count), 255);
        drop_clear = 1'b1;
        tick();
        chk("sat_cleared", 32'(drop_count), 0);
        drop_clear = 1'b0;
        tick();
        chk("sat_resume", 32'(drop_count), 1);
        pulse_in = '0;

        // Reset mid-operation discards queued and pending events.
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(event_valid), 0);
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_drop",  32'(drop_count), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("postrst_valid", 32'(event_valid), 0);
        chk("postrst_count", 32'(fifo_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
